// File: rtl/sync_sched_pkg.sv
// Shared types and helpers for the synchronized request scheduler.
package sync_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first pending line after last_grant, wrapping to 0.
module rr_pick
  import sync_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDW-1:0]   last_grant,
  output logic             found,
  output logic [IDW-1:0]   winner,
  output logic [N_REQ-1:0] winner_onehot
);

  logic [IDW-1:0] idx;

  always_comb begin
    found         = 1'b0;
    winner        = '0;
    winner_onehot = '0;
    idx           = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IDW'((32'(last_grant) + k) % N_REQ);
      if (!found && pending[idx]) begin
        found         = 1'b1;
        winner        = idx;
        winner_onehot = N_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/sync_req_scheduler.sv
// Round-robin scheduler sharing one consumer among synchronized request lines.
// Optional watchdog abort enabled by defining SYNC_SCHED_WATCHDOG_EN.
module sync_req_scheduler
  import sync_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_sync,
  input  logic             done,
  input  logic             clear_overrun,
  output logic             start,
  output logic [IDW-1:0]   grant_id,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             busy,
  output logic [N_REQ-1:0] overrun,
  output logic             timeout_err
);

  state_t           state;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] grant_vec;
  logic [N_REQ-1:0] win_onehot;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   win_id;
  logic             found;
  logic             grant_now;
  logic             done_ok;
  logic             wd_expire;

  assign rise      = req_sync & ~req_q;
  assign grant_now = (state == IDLE) && found;
  assign grant_vec = grant_now ? win_onehot : '0;
  // done arriving together with start belongs to no transaction yet
  assign done_ok   = done && !start;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDW  (IDW)
  ) u_pick (
    .pending      (pending),
    .last_grant   (last_grant),
    .found        (found),
    .winner       (win_id),
    .winner_onehot(win_onehot)
  );

  // Edge detect, one pending slot per line, sticky overrun (set beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      req_q   <= req_sync;
      pending <= (pending & ~grant_vec) | rise;
      overrun <= (overrun & {N_REQ{~clear_overrun}}) | (rise & pending & ~grant_vec);
    end
  end

  // Grant FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= IDW'(N_REQ - 1);
      start        <= 1'b0;
      grant_id     <= '0;
      grant_onehot <= '0;
      busy         <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state        <= BUSY;
            start        <= 1'b1;
            grant_id     <= win_id;
            grant_onehot <= win_onehot;
            busy         <= 1'b1;
            last_grant   <= win_id;
          end
        end
        BUSY: begin
          if (done_ok || wd_expire) begin
            state        <= IDLE;
            busy         <= 1'b0;
            grant_onehot <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYNC_SCHED_WATCHDOG_EN
  localparam int unsigned CW = clog2(TIMEOUT);

  logic [CW-1:0] wd_cnt;

  assign wd_expire = (state == BUSY) && (wd_cnt == CW'(TIMEOUT - 1));

  // Counts BUSY cycles from the grant; done in the expiry cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_expire && !done_ok;
      if (grant_now) begin
        wd_cnt <= '0;
      end else if (state == BUSY) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT);
  assign wd_expire      = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sync_req_scheduler.sv
// Directed plus randomized bench for sync_req_scheduler against a cycle-level reference model.
module tb_sync_req_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk;
  logic         reset;
  logic [N-1:0] req_sync;
  logic         done;
  logic         clear_overrun;
  logic         start;
  logic [1:0]   grant_id;
  logic [N-1:0] grant_onehot;
  logic         busy;
  logic [N-1:0] overrun;
  logic         timeout_err;

  sync_req_scheduler #(
    .N_REQ  (N),
    .IDW    (2),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_sync     (req_sync),
    .done         (done),
    .clear_overrun(clear_overrun),
    .start        (start),
    .grant_id     (grant_id),
    .grant_onehot (grant_onehot),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef SYNC_SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  // Reference model state
  bit m_pend[N];
  bit m_over[N];
  bit m_prev[N];
  int m_last, m_gid, m_cnt;
  bit m_busy, m_start, m_to;

  int n_cmp, n_bad, tcount;
  int lat_fix, lat, dcnt;
  bit noise;
  int grants[$];
  int st_times[$];
  int to_times[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_over[i] = 1'b0;
      m_prev[i] = 1'b0;
    end
    m_last  = N - 1;
    m_gid   = 0;
    m_cnt   = 0;
    m_busy  = 1'b0;
    m_start = 1'b0;
    m_to    = 1'b0;
    dcnt    = 0;
    lat     = 1;
    done    = 1'b0;
  endtask

  function automatic int model_pick();
    int w;
    int idx;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (w < 0 && m_pend[idx]) w = idx;
    end
    return w;
  endfunction

  task automatic model_step();
    int win;
    bit old_start;
    bit r;
    old_start = m_start;
    win       = m_busy ? -1 : model_pick();
    m_start   = 1'b0;
    m_to      = 1'b0;
    if (m_busy) begin
      if (done && !old_start) m_busy = 1'b0;
      else if (WD && m_cnt == TO - 1) begin
        m_busy = 1'b0;
        m_to   = 1'b1;
      end else m_cnt++;
    end else if (win >= 0) begin
      m_busy  = 1'b1;
      m_start = 1'b1;
      m_gid   = win;
      m_last  = win;
      m_cnt   = 0;
    end
    for (int i = 0; i < N; i++) begin
      r = req_sync[i] && !m_prev[i];
      if (clear_overrun) m_over[i] = 1'b0;
      if (r && m_pend[i] && i != win) m_over[i] = 1'b1;
      if (i == win) m_pend[i] = 1'b0;
      if (r) m_pend[i] = 1'b1;
      m_prev[i] = req_sync[i];
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eoh;
    logic [N-1:0] eov;
    eoh = m_busy ? N'(1 << m_gid) : '0;
    for (int i = 0; i < N; i++) eov[i] = m_over[i];
    chk("start", start, m_start);
    chk("grant_id", grant_id, m_gid);
    chk("grant_onehot", grant_onehot, eoh);
    chk("busy", busy, m_busy);
    chk("overrun", overrun, eov);
    chk("timeout_err", timeout_err, m_to);
  endtask

  // Consumer: done after lat cycles; lat 0 means done held level from start.
  task automatic consumer();
    if (m_start) begin
      lat  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 5));
      dcnt = lat;
      done = (lat == 0);
    end else if (m_busy) begin
      if (lat == 0) done = 1'b1;
      else begin
        if (dcnt > 0) dcnt--;
        done = (dcnt == 0);
      end
    end else begin
      done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    tcount++;
    #1;
    check_outputs();
    if (start === 1'b1) begin
      grants.push_back(int'(grant_id));
      st_times.push_back(tcount);
    end
    if (timeout_err === 1'b1) to_times.push_back(tcount);
    consumer();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    grants.delete();
    st_times.delete();
    to_times.delete();
  endtask

  initial begin
    int t0, nb, ones;
    bit fired;
    logic [N-1:0] oh_seen;
    logic [31:0] r;
    n_cmp = 0; n_bad = 0; tcount = 0;
    reset = 1'b1; req_sync = '0; clear_overrun = 1'b0;
    lat_fix = 5; noise = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;

    // Single request on line 2, consumer done 5 cycles after start
    grants.delete(); st_times.delete();
    req_sync = 4'b0100; t0 = tcount; nb = 0; oh_seen = '0;
    for (int c = 0; c < 14; c++) begin
      if (c == 3) req_sync = '0;
      tick();
      if (busy === 1'b1) nb++;
      if (start === 1'b1) oh_seen = grant_onehot;
    end
    chk("t1_ngrants", grants.size(), 1);
    if (grants.size() > 0) begin
      chk("t1_gid", grants[0], 2);
      chk("t1_latency", st_times[0] - t0, 2);
    end
    chk("t1_onehot", oh_seen, 4'b0100);
    chk("t1_busy_cycles", nb, 6);

    // Simultaneous rises 1011 after reset: order 0,1,3 with latency+2 spacing
    do_reset();
    lat_fix = 2;
    req_sync = 4'b1011;
    tick();
    req_sync = '0;
    repeat (30) tick();
    chk("t2_ngrants", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("t2_g0", grants[0], 0);
      chk("t2_g1", grants[1], 1);
      chk("t2_g2", grants[2], 3);
      chk("t2_gap01", st_times[1] - st_times[0], 4);
      chk("t2_gap12", st_times[2] - st_times[1], 4);
    end
    chk("t2_idle_end", busy, 0);

    // All lines re-requesting: fairness and wrap-around
    do_reset();
    lat_fix = -1;
    for (int t = 0; t < 40; t++) begin
      req_sync = (t % 2 == 0) ? 4'hF : 4'h0;
      tick();
    end
    chk("t3_ngrants_ge5", grants.size() >= 5, 1);
    if (grants.size() >= 5) begin
      chk("t3_g0", grants[0], 0);
      chk("t3_g1", grants[1], 1);
      chk("t3_g2", grants[2], 2);
      chk("t3_g3", grants[3], 3);
      chk("t3_g4", grants[4], 0);
    end
    req_sync = '0;
    tick();
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("t3_ovr_cleared", overrun, 0);
    repeat (30) tick();
    chk("t3_drained", busy, 0);

    // Overrun on line 1 while line 0 busy
    do_reset();
    lat_fix = 8;
    req_sync = 4'b0011;
    tick();
    tick();
    req_sync[1] = 1'b0;
    tick();
    req_sync[1] = 1'b1;
    tick();
    chk("t4_overrun", overrun, 4'b0010);
    req_sync = '0;
    repeat (25) tick();
    ones = 0;
    foreach (grants[i]) if (grants[i] == 1) ones++;
    chk("t4_ngrants", grants.size(), 2);
    chk("t4_grants_to_1", ones, 1);
    chk("t4_sticky", overrun, 4'b0010);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("t4_cleared", overrun, 0);

    // Rise on line 0 in the very cycle it is granted
    do_reset();
    lat_fix = 6;
    req_sync = 4'b0010;
    tick();
    req_sync = '0;
    tick();
    tick();
    req_sync[0] = 1'b1;
    tick();
    fired = 1'b0;
    for (int c = 0; c < 30; c++) begin
      req_sync[0] = 1'b0;
      if (!fired && !m_busy && model_pick() == 0) begin
        req_sync[0] = 1'b1;
        fired = 1'b1;
      end
      tick();
    end
    chk("t5_ngrants", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("t5_g0", grants[0], 1);
      chk("t5_g1", grants[1], 0);
      chk("t5_g2", grants[2], 0);
    end
    chk("t5_no_overrun", overrun, 0);

    // Withheld done: watchdog abort or indefinite wait
    do_reset();
    lat_fix = 1000;
    req_sync = 4'b0100;
    tick();
    req_sync = '0;
    repeat (40) tick();
    chk("t6_ngrants", grants.size(), 1);
`ifdef SYNC_SCHED_WATCHDOG_EN
    chk("t6_ntimeouts", to_times.size(), 1);
    if (to_times.size() == 1 && st_times.size() == 1)
      chk("t6_timeout_delay", to_times[0] - st_times[0], TO);
    chk("t6_busy_dropped", busy, 0);
`else
    chk("t6_ntimeouts", to_times.size(), 0);
    chk("t6_still_busy", busy, 1);
`endif

    // Asynchronous reset in the middle of a transaction
    req_sync = 4'b1000;
    tick();
    req_sync = '0;
    tick();
    tick();
    chk("t7_pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("t7_async_reset", {start, grant_id, grant_onehot, busy, overrun, timeout_err}, 0);
    model_reset();
    tick();
    reset = 1'b0;

    // Randomized traffic with noisy idle done and random overrun clears
    lat_fix = -1;
    noise = 1'b1;
    for (int t = 0; t < 400; t++) begin
      r = $urandom;
      req_sync = req_sync ^ (r[3:0] & r[7:4] & r[11:8]);
      clear_overrun = (r[15:12] == 4'd0);
      tick();
    end
    clear_overrun = 1'b0;
    noise = 1'b0;
    req_sync = '0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_req_scheduler.md
Name: sync_req_scheduler

Overview:
- Shares one consumer among N_REQ request sources, e.g. the flash-read / sample-fetch FSM.
- Each source is an asynchronous event that has already passed through a per-line pulse synchronizer into this block's clock domain.
- The block edge-detects each line, latches it as pending, and grants the consumer round-robin through a start/done handshake.
- Overruns are flagged; an optional watchdog is available.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- IDW, 2: width of grant_id; must equal clog2(N_REQ).
- TIMEOUT, 1024: watchdog limit in clk cycles. Used only with the watchdog macro; must be >= 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_sync  in  N_REQ  synchronized request levels, one per source.
- done  in  1  consumer completion; single-cycle or level.
- clear_overrun  in  1  clears all overrun flags.
- start  out  1  one-cycle pulse launching the consumer.
- grant_id  out  IDW  index of the current or last granted requester.
- grant_onehot  out  N_REQ  one-hot grant; held for all of BUSY, 0 otherwise.
- busy  out  1  high while a transaction is outstanding.
- overrun  out  N_REQ  sticky flag: a request arrived while the same line was still pending.
- timeout_err  out  1  one-cycle pulse on watchdog abort; tied 0 without the macro.

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal state: pending=0, req_q=0, state=IDLE.
  - last_grant=N_REQ-1, so requester 0 wins first.
  - A req_sync line already high at reset release counts as one rising edge.
- Edge detect and pending:
  - rise = req_sync & ~req_q; req_q registers req_sync every cycle.
  - pending[i] sets on rise[i] and clears in the cycle i is granted.
  - If rise[i] coincides with the grant of i, pending[i] stays set (a new request).
- Overrun:
  - If rise[i] occurs while pending[i]=1 and i is not being granted that cycle, overrun[i] sets.
  - No second request is queued; one pending slot per line.
  - clear_overrun clears all flags. Same-cycle set and clear: set wins.
- FSM states: IDLE, BUSY.
  - IDLE: if |pending, select the winner round-robin, searching from last_grant+1 and wrapping at N_REQ-1 to 0. On the next edge:
    - state goes to BUSY;
    - start=1 for exactly that one cycle;
    - grant_id and grant_onehot are set to the winner;
    - pending[winner] clears and last_grant updates to the winner.
  - IDLE with no pending: stay in IDLE, outputs static.
  - BUSY: busy=1 and grant_onehot is held.
    - done is ignored in the cycle where start=1.
    - done seen high in any later cycle returns the FSM to IDLE on the next edge: busy=0, grant_onehot=0, grant_id holds its value.
- Throughput:
  - There is one mandatory IDLE cycle between transactions.
  - Latency: req_sync rising before edge k gives pending after edge k and start after edge k+1.
  - Back-to-back grants are therefore at best 1 start per (consumer latency + 2) cycles.
- done while in IDLE is ignored.
- Simultaneous rises on several lines: all go pending and are serviced in round-robin order from last_grant+1.
- Reset mid-transaction returns to the reset state immediately. The consumer must tolerate an abandoned transaction.

Optional Feature:
- SYNC_SCHED_WATCHDOG_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT-1 without done, the FSM goes to IDLE with timeout_err=1 for one cycle.
  - The aborted requester is not re-queued.
  - If done and timeout occur in the same cycle, done wins and timeout_err stays 0.
- Undefined: no counter is built, timeout_err is constant 0, and BUSY waits indefinitely.

Decomposition:
- sync_sched_pkg contains:
  - the state typedef {IDLE, BUSY};
  - a clog2 helper function;
  - the default TIMEOUT constant.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: pending, last_grant.
  - Outputs: found, winner index, winner one-hot.
  - Instantiated once.

Test Plan:
- N_REQ=4; pulse req_sync[2] high for 3 cycles; consumer asserts done 5 cycles after start -> start 2 cycles after the rise, grant_id=2, grant_onehot=4'b0100, busy high 6 cycles.
- req_sync=4'b1011 rising in one cycle after reset -> grant order 0,1,3; each start separated by done + 1 IDLE cycle; pending=0 at end.
- Starting from last_grant=3, hold all four lines pending across repeated re-requests -> grant sequence 0,1,2,3,0 (fairness and wrap-around).
- While requester 1 is pending but not yet granted (requester 0 busy), toggle req_sync[1] low then high -> overrun=4'b0010; no extra grant to 1; clear_overrun clears it.
- Rise on line 0 exactly in the cycle line 0 is granted -> a second grant of 0 after done, no overrun.
- With SYNC_SCHED_WATCHDOG_EN and TIMEOUT=16, withhold done -> timeout_err pulses 16 cycles after start, busy drops; assert reset mid-BUSY -> all outputs 0 within the same cycle.
